// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The control bundle field order is the one every pipeline-register instance uses.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic freeze;
    logic flush;
  } stage_ctrl_t;

  typedef struct packed {
    logic        pc_we;
    logic        pc_redirect;
    stage_ctrl_t if_id;
    stage_ctrl_t id_ex;
    stage_ctrl_t ex_mem;
    logic        mem_wb_flush;
  } ctrl_bundle_t;

  // Control rows, in the field order of ctrl_bundle_t
  localparam ctrl_bundle_t CTRL_RESET    = '{1'b0, 1'b0, '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b0, 1'b1}, 1'b1};
  localparam ctrl_bundle_t CTRL_DSTALL   = '{1'b0, 1'b0, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, 1'b1};
  localparam ctrl_bundle_t CTRL_REDIRECT = '{1'b1, 1'b1, '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b0, 1'b0}, 1'b0};
  localparam ctrl_bundle_t CTRL_MDU      = '{1'b0, 1'b0, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b1}, 1'b0};
  localparam ctrl_bundle_t CTRL_LOADUSE  = '{1'b0, 1'b0, '{1'b1, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b0}, 1'b0};
  localparam ctrl_bundle_t CTRL_RUN      = '{1'b1, 1'b0, '{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b0, 1'b0}, 1'b0};

endpackage

// File: rtl/pipe_loaduse_det.sv
// Load-use hazard comparator: the ID instruction reads the register a load in EX is writing.
module pipe_loaduse_det
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  lu_c
);

  logic rd_valid;
  logic hit_rs1;
  logic hit_rs2;

  // Writes to x0 are discarded, so they never create a dependency
  assign rd_valid = ex_mem_read && (ex_rd != '0);
  assign hit_rs1  = use_rs1 && (rs1 == ex_rd);
  assign hit_rs2  = use_rs2 && (rs2 == ex_rd);
  assign lu_c     = rd_valid && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: resolves load-use, redirect, MDU and dmem-wait hazards
// into PC and pipeline-register freeze/flush controls, and counts stall/flush cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 8,
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_use_rs1,
  input  logic                  ID_use_rs2,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_mem_read,
  input  logic                  EX_redirect,
  input  logic                  EX_mdu_start,
  input  logic                  dmem_stall,
  output logic                  pc_we,
  output logic                  pc_redirect,
  output logic                  IF_ID_freeze,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_freeze,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_freeze,
  output logic                  EX_MEM_flush,
  output logic                  MEM_WB_flush,
  output logic                  mdu_done,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam int unsigned CNT_W     = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam bit          MDU_MULTI = (MDU_LATENCY > 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  ctrl_bundle_t     ctrl;
  logic             lu;

  pipe_loaduse_det #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_loaduse_det (
    .rs1         (ID_rs1),
    .rs2         (ID_rs2),
    .use_rs1     (ID_use_rs1),
    .use_rs2     (ID_use_rs2),
    .ex_rd       (EX_rd),
    .ex_mem_read (EX_mem_read),
    .lu_c        (lu)
  );

  // State, MDU down-counter and performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!ctrl.pc_we) stall_cnt <= stall_cnt + 32'd1;
      if (ctrl.pc_redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  // Hazard priority resolution and next-state logic
  always_comb begin
    ctrl      = CTRL_RUN;
    mdu_done  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!rst) begin
      ctrl      = CTRL_RESET;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_stall) begin
            ctrl = CTRL_DSTALL;
          end else if (EX_redirect) begin
            ctrl = CTRL_REDIRECT;
          end else if (EX_mdu_start && MDU_MULTI) begin
            ctrl      = CTRL_MDU;
            state_nxt = MDU_BUSY;
            cnt_nxt   = CNT_W'(MDU_LATENCY - 2);
          end else if (lu) begin
            ctrl = CTRL_LOADUSE;
          end
        end
        MDU_BUSY: begin
          // A dmem wait at cnt==0 holds the result until memory is ready
          if (dmem_stall) begin
            ctrl = CTRL_DSTALL;
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
          end else if (cnt != '0) begin
            ctrl    = CTRL_MDU;
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            mdu_done  = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pc_we         = ctrl.pc_we;
  assign pc_redirect   = ctrl.pc_redirect;
  assign IF_ID_freeze  = ctrl.if_id.freeze;
  assign IF_ID_flush   = ctrl.if_id.flush;
  assign ID_EX_freeze  = ctrl.id_ex.freeze;
  assign ID_EX_flush   = ctrl.id_ex.flush;
  assign EX_MEM_freeze = ctrl.ex_mem.freeze;
  assign EX_MEM_flush  = ctrl.ex_mem.flush;
  assign MEM_WB_flush  = ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, each cycle
// compared against a cycle-count based reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        use1, use2, mem_read, redirect, mdu_start, dstall;
  logic        pc_we, pc_redirect, ifid_frz, ifid_fl, idex_frz, idex_fl;
  logic        exmem_frz, exmem_fl, memwb_fl, mdu_done;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: MDU busy flag with the cycle number it started on
  int          cyc       = 0;
  bit          busy      = 1'b0;
  int          start_cyc = 0;
  logic [31:0] stall_m   = '0;
  logic [31:0] flush_m   = '0;

  // Expected vector {pc_we, pc_redirect, ifid frz/fl, idex frz/fl, exmem frz/fl, memwb fl, mdu_done}
  localparam logic [9:0] E_RESET  = 10'b00_01_01_01_1_0;
  localparam logic [9:0] E_DSTALL = 10'b00_10_10_10_1_0;
  localparam logic [9:0] E_REDIR  = 10'b11_01_01_00_0_0;
  localparam logic [9:0] E_MDU    = 10'b00_10_10_01_0_0;
  localparam logic [9:0] E_LU     = 10'b00_10_01_00_0_0;
  localparam logic [9:0] E_RUN    = 10'b10_00_00_00_0_0;
  localparam logic [9:0] E_DONE   = 10'b10_00_00_00_0_1;

  pipe_hazard_ctrl #(.MDU_LATENCY(L), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1       (id_rs1),
    .ID_rs2       (id_rs2),
    .ID_use_rs1   (use1),
    .ID_use_rs2   (use2),
    .EX_rd        (ex_rd),
    .EX_mem_read  (mem_read),
    .EX_redirect  (redirect),
    .EX_mdu_start (mdu_start),
    .dmem_stall   (dstall),
    .pc_we        (pc_we),
    .pc_redirect  (pc_redirect),
    .IF_ID_freeze (ifid_frz),
    .IF_ID_flush  (ifid_fl),
    .ID_EX_freeze (idex_frz),
    .ID_EX_flush  (idex_fl),
    .EX_MEM_freeze(exmem_frz),
    .EX_MEM_flush (exmem_fl),
    .MEM_WB_flush (memwb_fl),
    .mdu_done     (mdu_done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic rdr, input logic ms, input logic ds);
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    bit         hazard;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; use1 = u1; use2 = u2;
    ex_rd = rd; mem_read = mr; redirect = rdr; mdu_start = ms; dstall = ds;
    assert (!(rdr && ms)) else begin
      failures++;
      $error("FAIL illegal_stimulus redirect=%0b mdu_start=%0b required both not 1", rdr, ms);
    end
    #2;
    hazard = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r)                                exp_v = E_RESET;
    else if (busy && cyc >= start_cyc + int'(L) - 1 && !ds) exp_v = E_DONE;
    else if (busy)                         exp_v = ds ? E_DSTALL : E_MDU;
    else if (ds)                           exp_v = E_DSTALL;
    else if (rdr)                          exp_v = E_REDIR;
    else if (ms && L > 1)                  exp_v = E_MDU;
    else if (hazard)                       exp_v = E_LU;
    else                                   exp_v = E_RUN;
    obs_v = {pc_we, pc_redirect, ifid_frz, ifid_fl, idex_frz, idex_fl,
             exmem_frz, exmem_fl, memwb_fl, mdu_done};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL ctrl cyc=%0d observed=%b expected=%b", cyc, obs_v, exp_v);
    end
    checks++;
    assert (stall_cnt === stall_m) else begin
      failures++;
      $error("FAIL stall_cnt cyc=%0d observed=%0d expected=%0d", cyc, stall_cnt, stall_m);
    end
    checks++;
    assert (flush_cnt === flush_m) else begin
      failures++;
      $error("FAIL flush_cnt cyc=%0d observed=%0d expected=%0d", cyc, flush_cnt, flush_m);
    end
    if (!r) begin
      busy = 1'b0; stall_m = '0; flush_m = '0;
    end else begin
      if (!busy && !ds && !rdr && ms && L > 1) begin
        busy = 1'b1; start_cyc = cyc;
      end else if (exp_v == E_DONE) begin
        busy = 1'b0;
      end
      if (!exp_v[9]) stall_m = stall_m + 32'd1;
      if (exp_v[8])  flush_m = flush_m + 32'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] s0;
    logic        r;
    logic        rdr;
    logic        ms;
    @(posedge clk);
    #1;
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Load-use on rs1, then the load moves to MEM
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    // Load to x0 never stalls; rs2 hit does
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // Redirect beats load-use
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    // MDU: L-1 frozen cycles then mdu_done
    s0 = stall_cnt;
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= int'(L); k++) idle();
    checks++;
    assert (stall_cnt - s0 === 32'd7) else begin
      failures++;
      $error("FAIL mdu_stall_delta observed=%0d expected=7", stall_cnt - s0);
    end
    // MDU with dmem_stall at offsets 5..9: done moves to offset 10
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++)
      step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, (k >= 5 && k <= 9));
    // Redirect held under 3 cycles of dmem_stall
    for (int k = 0; k < 3; k++)
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    // Reset in the middle of an MDU op
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < int'(L) + 2; k++) idle();
    // Random traffic
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 79) != 0);
      rdr = ($urandom_range(0, 5) == 0);
      ms  = !rdr && ($urandom_range(0, 7) == 0);
      step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
           1'($urandom), rdr, ms, ($urandom_range(0, 4) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
